// File: rtl/mips_multicycle_control_if.sv
// Shared memory-port handshake between the multi-cycle control FSM and the memory.
// The master side (control) requests; the slave side (memory) signals completion.
interface mips_multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over the
// shared datapath, drives all mux selects and enables, and flags illegal opcodes and bus timeouts.
module mips_multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [5:0]                  opcode,
    input  logic [5:0]                  alu_function,
    input  logic                        alu_zero,
    mips_multicycle_control_if.master   mem,
    output logic                        iord,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic [1:0]                  pc_src,
    output logic                        alu_src_a,
    output logic [1:0]                  alu_src_b,
    output logic [1:0]                  alu_op,
    output logic                        reg_write,
    output logic                        reg_dst,
    output logic                        mem_to_reg,
    output logic                        instr_retired,
    output logic                        illegal_instr,
    output logic                        bus_error,
    output logic [3:0]                  state
);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StFetch    = 4'd1;
    localparam logic [3:0] StDecode   = 4'd2;
    localparam logic [3:0] StMemAddr  = 4'd3;
    localparam logic [3:0] StMemRead  = 4'd4;
    localparam logic [3:0] StMemWb    = 4'd5;
    localparam logic [3:0] StMemWrite = 4'd6;
    localparam logic [3:0] StExecute  = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;
    localparam logic [3:0] StJump     = 4'd10;
    localparam logic [3:0] StJumpReg  = 4'd11;
    localparam logic [3:0] StImmExec  = 4'd12;
    localparam logic [3:0] StImmWb    = 4'd13;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08;

    localparam logic [TIMEOUT_W-1:0] TimeoutLimit = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [3:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 mem_state;
    logic                 timeout;

    assign state = state_q;

    always_comb begin
        mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
        timeout   = mem_state && !mem.mem_ready && (TIMEOUT_CYCLES != 0) &&
                    (tmo_cnt_q == TimeoutLimit);
    end

    always_comb begin
        state_d       = state_q;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = timeout;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b01;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRtype:    state_d = (alu_function == FnJr) ? StJumpReg : StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StImmExec;
                    OpJ:        state_d = StJump;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem.mem_req = 1'b1;
                iord        = 1'b1;
                if (mem.mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    state_d = StFetch;
                end
            end
            StMemWb: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                iord        = 1'b1;
                if (mem.mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = StFetch;
                end else if (timeout) begin
                    state_d = StFetch;
                end
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StImmExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StImmWb;
            end
            StImmWb: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_src        = 2'b01;
                pc_write      = alu_zero;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_write      = 1'b1;
                pc_src        = 2'b10;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StJumpReg: begin
                pc_write      = 1'b1;
                pc_src        = 2'b11;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    // Any state change (or a timeout retry of FETCH) restarts the wait count.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_d != state_q) || timeout) begin
            tmo_cnt_d = '0;
        end else if (mem_state && !mem.mem_ready) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: an instruction-level model expands each
// instruction into expected per-cycle control words; a negedge monitor compares them.
module tb_mips_multicycle_control;

    localparam int TO = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb, aop;
        logic       rw, rdst, m2r, ret, ill, berr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] alu_function = '0;
    logic       alu_zero = 1'b0;
    logic       iord, ir_write, pc_write, alu_src_a, reg_write, reg_dst, mem_to_reg;
    logic       instr_retired, illegal_instr, bus_error;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    mips_multicycle_control_if mem_if ();

    mips_multicycle_control #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_W      (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .alu_function  (alu_function),
        .alu_zero      (alu_zero),
        .mem           (mem_if),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .state         (state)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;
    logic       cur_zero = 1'b0;

    initial mem_if.mem_ready = 1'b0;

    always @(negedge clk) begin
        exp_t act, e;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = '{st: state, req: mem_if.mem_req, we: mem_if.mem_we, iord: iord,
                    irw: ir_write, pcw: pc_write, pcs: pc_src, asa: alu_src_a,
                    asb: alu_src_b, aop: alu_op, rw: reg_write, rdst: reg_dst,
                    m2r: mem_to_reg, ret: instr_retired, ill: illegal_instr,
                    berr: bus_error};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctl_word cycle %0d: got st=%0d word=%h, required st=%0d word=%h",
                         cyc, act.st, act, e.st, e);
            end
        end
    end

    function automatic exp_t z(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    // One clock cycle: apply inputs just after the edge, queue what the DUT must show.
    task automatic step(input logic rst, input logic rdy, input exp_t e);
        @(posedge clk);
        #1;
        reset_n          = rst;
        opcode           = cur_op;
        alu_function     = cur_fn;
        alu_zero         = cur_zero;
        mem_if.mem_ready = rdy;
        sb.push_back(e);
    endtask

    task automatic reset_seq();
        step(1'b0, 1'b0, z(4'd0));
        step(1'b0, 1'b0, z(4'd0));
        step(1'b1, 1'b0, z(4'd0));
    endtask

    // Memory access that waits 'waits' cycles; gives up after TO un-ready cycles.
    task automatic mem_phase(input exp_t hold, input exp_t done, input int waits,
                             output bit tmo);
        exp_t b;
        tmo = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                step(1'b1, 1'b1, done);
                return;
            end
            if (TO != 0 && i == TO) begin
                b = hold;
                b.berr = 1'b1;
                step(1'b1, 1'b0, b);
                tmo = 1'b1;
                return;
            end
            step(1'b1, 1'b0, hold);
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                            input int wf, input int wm, input bit rst_in_exec);
        exp_t h, d, e;
        bit   tmo;
        cur_op = op;
        cur_fn = fn;
        cur_zero = zero;

        h = z(4'd1); h.req = 1'b1; h.asb = 2'b01;
        d = h; d.irw = 1'b1; d.pcw = 1'b1;
        mem_phase(h, d, wf, tmo);
        if (tmo) return;

        e = z(4'd2); e.asb = 2'b11;
        if (!(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02})) begin
            e.ill = 1'b1;
            step(1'b1, 1'b0, e);
            return;
        end
        step(1'b1, 1'b0, e);

        if (op == 6'h23 || op == 6'h2B) begin
            e = z(4'd3); e.asa = 1'b1; e.asb = 2'b10;
            step(1'b1, 1'b0, e);
            if (op == 6'h23) begin
                h = z(4'd4); h.req = 1'b1; h.iord = 1'b1;
                mem_phase(h, h, wm, tmo);
                if (!tmo) begin
                    e = z(4'd5); e.rw = 1'b1; e.m2r = 1'b1; e.ret = 1'b1;
                    step(1'b1, 1'b0, e);
                end
            end else begin
                h = z(4'd6); h.req = 1'b1; h.we = 1'b1; h.iord = 1'b1;
                d = h; d.ret = 1'b1;
                mem_phase(h, d, wm, tmo);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            e = z(4'd11); e.pcw = 1'b1; e.pcs = 2'b11; e.ret = 1'b1;
            step(1'b1, 1'b0, e);
        end else if (op == 6'h00) begin
            if (rst_in_exec) begin
                reset_seq();
                return;
            end
            e = z(4'd7); e.asa = 1'b1; e.aop = 2'b10;
            step(1'b1, 1'b0, e);
            e = z(4'd8); e.rw = 1'b1; e.rdst = 1'b1; e.ret = 1'b1;
            step(1'b1, 1'b0, e);
        end else if (op == 6'h04) begin
            e = z(4'd9); e.asa = 1'b1; e.aop = 2'b01; e.pcs = 2'b01;
            e.pcw = zero; e.ret = 1'b1;
            step(1'b1, 1'b0, e);
        end else if (op == 6'h08) begin
            e = z(4'd12); e.asa = 1'b1; e.asb = 2'b10;
            step(1'b1, 1'b0, e);
            e = z(4'd13); e.rw = 1'b1; e.ret = 1'b1;
            step(1'b1, 1'b0, e);
        end else begin
            e = z(4'd10); e.pcw = 1'b1; e.pcs = 2'b10; e.ret = 1'b1;
            step(1'b1, 1'b0, e);
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 6));
    endfunction

    initial begin
        logic [5:0] legal[6];
        logic [5:0] bad[6];
        logic [5:0] op, fn;
        legal = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
        bad   = '{6'h3F, 6'h01, 6'h03, 6'h0F, 6'h2A, 6'h10};

        reset_seq();
        do_instr(6'h23, 6'h00, 1'b0, 0, 0, 1'b0);   // lw, zero waits
        do_instr(6'h2B, 6'h00, 1'b0, 0, 3, 1'b0);   // sw, 3 waits in MEM_WRITE
        do_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
        do_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
        do_instr(6'h23, 6'h00, 1'b0, 5, 0, 1'b0);   // FETCH timeout
        do_instr(6'h23, 6'h00, 1'b0, 0, 0, 1'b0);
        do_instr(6'h08, 6'h00, 1'b0, 4, 0, 1'b0);   // ready exactly at the limit
        do_instr(6'h23, 6'h00, 1'b0, 0, 6, 1'b0);   // MEM_READ timeout
        do_instr(6'h2B, 6'h00, 1'b0, 1, 4, 1'b0);
        do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
        do_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
        do_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
        do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b1);   // reset during EXECUTE
        do_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) op = bad[$urandom_range(0, 5)];
            else op = legal[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            do_instr(op, fn, 1'($urandom_range(0, 1)), rand_wait(), rand_wait(),
                     $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS core. It sits after the instruction decoder.
- Consumes the decoded opcode/funct fields and sequences fetch, decode, execute, memory and writeback over the shared ALU/memory datapath.
- Drives all datapath mux selects and write enables, and handshakes with a single shared memory port.
- Detects illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, max wait cycles for mem_ready before bus_error; 0 disables the timeout.
- TIMEOUT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the decoder.
- alu_function  in  6  instruction[5:0] from the decoder.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- iord  out  1  memory address source: 0 = PC, 1 = ALU out.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  PC write enable.
- pc_src  out  2  PC source: 00 = ALU (PC+4), 01 = branch target reg, 10 = jump target, 11 = rs.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = use funct.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data: 0 = ALU, 1 = memory.
- instr_retired  out  1  1-cycle pulse when an instruction completes.
- illegal_instr  out  1  1-cycle pulse on an unsupported opcode.
- bus_error  out  1  1-cycle pulse on memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Reset (async, reset_n=0): state=IDLE(0), timeout counter=0. Every output is 0 while in reset and in IDLE. IDLE goes to FETCH on the next clock.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, JUMP_REG=11, IMM_EXEC=12, IMM_WB=13.
- Outputs are combinational from the state; any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. Holds until mem_ready=1. In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR.
  - 0x00 with funct 0x08 -> JUMP_REG.
  - 0x00 with any other funct -> EXECUTE.
  - 0x04 (beq) -> BRANCH.
  - 0x08 (addi) -> IMM_EXEC.
  - 0x02 (j) -> JUMP.
  - Any other opcode: illegal_instr=1 this cycle, next state FETCH, no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, iord=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_retired=1. Next state FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. In the mem_ready cycle: instr_retired=1, next state FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_retired=1. Next state FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, instr_retired=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=alu_zero, instr_retired=1. Next state FETCH.
- JUMP: pc_write=1, pc_src=10, instr_retired=1. Next state FETCH.
- JUMP_REG: pc_write=1, pc_src=11, instr_retired=1. Next state FETCH.
- Timeout counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle one of these states is held with mem_ready=0.
  - If the counter equals TIMEOUT_CYCLES and mem_ready=0 (TIMEOUT_CYCLES≠0): bus_error=1, next state FETCH. No ir_write, pc_write or retire in that cycle.
  - mem_ready=1 in the same cycle as the limit: the access completes normally and bus_error stays 0.
- Latency with zero memory wait states: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, jr 3.
- mem_req stays asserted continuously until the mem_ready or timeout cycle.
- reset_n low mid-operation forces IDLE immediately; there is no partial writeback.

Test Plan:
- Reset, then mem_ready tied to 1 and instruction lw (opcode 0x23) -> state sequence 1,2,3,4,5,1; reg_write and mem_to_reg both 1 in state 5; one instr_retired pulse; 5 cycles per instruction.
- sw (0x2B) with mem_ready delayed 3 cycles in MEM_WRITE -> mem_req=1 and mem_we=1 held for 4 cycles; instr_retired only in the mem_ready cycle.
- beq (0x04) run with alu_zero=1, then with alu_zero=0 -> pc_write=1 with pc_src=01 in the first case; pc_write=0 in the second; both retire.
- Opcode 0x3F -> illegal_instr pulse in DECODE; next state FETCH; instr_retired and reg_write stay 0.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> bus_error pulse on the 5th FETCH cycle; state returns to FETCH with the counter cleared. Then mem_ready=1 -> normal fetch.
- R-type with funct 0x20 (4 cycles, reg_dst=1, alu_op=10), then funct 0x08 (JUMP_REG, pc_src=11). Assert reset_n=0 during EXECUTE -> immediate IDLE, all outputs 0.
